// File: rtl/resource_arb_pkg.sv
// Shared definitions for the four-way round-robin resource arbiter.
package resource_arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StGap
  } arb_state_e;

  // Index to one-hot grant vector.
  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // One-hot vector to index; an all-zero vector maps to index 0.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner search: first eligible bit after last_i, wrapping.
module rr_pick
  import resource_arb_pkg::*;
(
  input  logic [N_REQ-1:0] elig_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = int'(N_REQ); k >= 1; k--) begin
      cand = last_i + IDX_W'(k);  // natural wrap modulo N_REQ
      if (elig_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/resource_rr_arbiter.sv
// Four-requester round-robin arbiter with registered one-hot grant and a dead gap
// between owners. Define TENURE_LIMIT_EN to enable the hold counter, forced
// revocation after MAX_HOLD cycles, and the re-request block mask.
module resource_rr_arbiter
  import resource_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] owner_o,
  output logic             busy_o,
  output logic             revoked_o
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255 || MAX_HOLD >= (1 << HOLD_W)) begin : g_bad_cfg
    $error("resource_rr_arbiter: MAX_HOLD/HOLD_W out of range");
  end

  arb_state_e       state_q;
  logic [N_REQ-1:0] grant_q;
  logic [IDX_W-1:0] owner_q;
  logic [IDX_W-1:0] last_q;
  logic [N_REQ-1:0] elig;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

`ifdef TENURE_LIMIT_EN
  logic [N_REQ-1:0]  block_mask_q;
  logic [HOLD_W-1:0] hold_q;
  logic              revoked_q;

  assign elig      = req_i & ~block_mask_q;
  assign revoked_o = revoked_q;
`else
  assign elig      = req_i;
  assign revoked_o = 1'b0;
`endif

  rr_pick u_rr_pick (
    .elig_i  (elig),
    .last_i  (last_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Arbitration FSM with registered grant, owner, hold counter and block mask.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      owner_q      <= '0;
      last_q       <= IDX_W'(N_REQ - 1);
`ifdef TENURE_LIMIT_EN
      block_mask_q <= '0;
      hold_q       <= '0;
      revoked_q    <= 1'b0;
`endif
    end else begin
`ifdef TENURE_LIMIT_EN
      revoked_q    <= 1'b0;
      // A dropped request lifts the block; a revocation below overrides for the owner.
      block_mask_q <= block_mask_q & req_i;
`endif
      unique case (state_q)
        StIdle: begin
          if (pick_found) begin
            state_q <= StGrant;
            grant_q <= idx_to_onehot(pick_idx);
            owner_q <= pick_idx;
            last_q  <= pick_idx;
`ifdef TENURE_LIMIT_EN
            hold_q  <= '0;
`endif
          end
        end
        StGrant: begin
          if (!req_i[owner_q]) begin
            // Release takes priority over a simultaneous tenure expiry.
            grant_q <= '0;
            state_q <= StGap;
          end
`ifdef TENURE_LIMIT_EN
          else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
            grant_q               <= '0;
            state_q               <= StGap;
            revoked_q             <= 1'b1;
            block_mask_q[owner_q] <= 1'b1;
          end else if (hold_q != '1) begin
            hold_q <= hold_q + 1'b1;
          end
`endif
        end
        StGap: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign grant_o = grant_q;
  assign owner_o = owner_q;
  assign busy_o  = |grant_q;

endmodule

// File: tb/tb_resource_rr_arbiter.sv
// Randomised scoreboard bench for resource_rr_arbiter against a behavioural model.
module tb_resource_rr_arbiter;

  localparam int unsigned MAX_HOLD = 4;
  localparam int unsigned HOLD_W   = 8;
`ifdef TENURE_LIMIT_EN
  localparam bit LimitOn = 1'b1;
`else
  localparam bit LimitOn = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req   = 4'b0000;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       busy;
  logic       revoked;

  always #5 clock = ~clock;

  resource_rr_arbiter #(
    .MAX_HOLD (MAX_HOLD),
    .HOLD_W   (HOLD_W)
  ) dut (
    .clock_i   (clock),
    .reset_i   (reset),
    .req_i     (req),
    .grant_o   (grant),
    .owner_o   (owner),
    .busy_o    (busy),
    .revoked_o (revoked)
  );

  typedef struct packed {
    logic [3:0] grant;
    logic       busy;
    logic [1:0] owner;
    logic       chk_owner;
    logic       revoked;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Behavioural model: current owner (-1 = nobody), pending gap, round-robin pointer,
  // cycles of grant seen so far, per-requester block flags.
  int m_own = -1;
  bit m_gap = 1'b0;
  int m_last = 3;
  int m_ten = 0;
  bit m_blk[4] = '{0, 0, 0, 0};
  bit m_rev = 1'b0;

  // Stimulus-side tenure control: remaining high cycles for the current owner.
  int cd = 0;
  int t_lo = 1;
  int t_hi = 1;

  task automatic model_step(input logic [3:0] r, input logic rst);
    bit   old_blk[4];
    exp_t e;
    old_blk = m_blk;
    m_rev   = 1'b0;
    if (rst) begin
      m_own  = -1;
      m_gap  = 1'b0;
      m_last = 3;
      m_ten  = 0;
      for (int i = 0; i < 4; i++) m_blk[i] = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) if (!r[i]) m_blk[i] = 1'b0;
      if (m_own >= 0) begin
        if (!r[m_own]) begin
          m_own = -1;
          m_gap = 1'b1;
        end else if (LimitOn && m_ten == int'(MAX_HOLD)) begin
          m_blk[m_own] = 1'b1;
          m_rev        = 1'b1;
          m_own        = -1;
          m_gap        = 1'b1;
        end else begin
          m_ten++;
        end
      end else if (m_gap) begin
        m_gap = 1'b0;
      end else begin
        for (int k = 1; k <= 4; k++) begin
          int c;
          c = (m_last + k) % 4;
          if (r[c] && !old_blk[c]) begin
            m_own  = c;
            m_last = c;
            m_ten  = 1;
            cd     = int'($urandom_range(t_lo, t_hi)) - 1;
            break;
          end
        end
      end
    end
    e.grant     = 4'b0000;
    e.owner     = 2'd0;
    if (m_own >= 0) begin
      e.grant[m_own] = 1'b1;
      e.owner        = 2'(m_own);
    end
    e.busy      = (m_own >= 0);
    e.chk_owner = (m_own >= 0) || rst;
    e.revoked   = m_rev;
    sb_q.push_back(e);
  endtask

  task automatic cycle(input logic [3:0] r, input logic rst);
    req   = r;
    reset = rst;
    model_step(r, rst);
    @(posedge clock);
    #1;
  endtask

  // rst_mode: 0 = no reset, 1 = reset held, 2 = occasional random reset.
  task automatic run(input int n, input logic [3:0] base, input bit rnd, input int lo,
                     input int hi, input int rst_mode);
    logic [3:0] r;
    logic       rst;
    t_lo = lo;
    t_hi = hi;
    if (m_own >= 0) cd = int'($urandom_range(lo, hi)) - 1;
    for (int j = 0; j < n; j++) begin
      r = rnd ? (4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15))) : base;
      if (m_own >= 0) begin
        r[m_own] = (cd > 0);
        if (cd > 0) cd--;
      end
      rst = (rst_mode == 1) || (rst_mode == 2 && $urandom_range(0, 99) < 2);
      cycle(r, rst);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("grant", int'(grant), int'(e.grant));
        check("busy", int'(busy), int'(e.busy));
        check("revoked", int'(revoked), int'(e.revoked));
        if (e.chk_owner) check("owner", int'(owner), int'(e.owner));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog at %0t: got timeout expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with all requesting, then rotation with short tenures.
    run(3, 4'b1111, 1'b0, 1, 1, 1);
    run(12, 4'b1111, 1'b0, 2, 2, 0);
    run(4, 4'b0000, 1'b0, 1, 1, 0);
    // Requesters 0 and 2, three-cycle tenures.
    run(20, 4'b0101, 1'b0, 3, 3, 0);
    run(3, 4'b0000, 1'b0, 1, 1, 0);
    // Requester 1 held high: revoked at the limit when enabled, then blocked.
    run(12, 4'b0010, 1'b0, 1000, 1000, 0);
    run(2, 4'b0000, 1'b0, 1, 1, 0);
    run(8, 4'b0010, 1'b0, 2, 2, 0);
    run(3, 4'b0000, 1'b0, 1, 1, 0);
    // Release on the very cycle the limit is reached.
    run(14, 4'b0010, 1'b0, MAX_HOLD, MAX_HOLD, 0);
    run(3, 4'b0000, 1'b0, 1, 1, 0);
    // Reset in the middle of requester 2's tenure; next grant searches from 0.
    run(3, 4'b0100, 1'b0, 1000, 1000, 0);
    run(1, 4'b1111, 1'b0, 1000, 1000, 1);
    run(4, 4'b1111, 1'b0, 2, 2, 0);
    // Random traffic with varied tenures and occasional resets.
    run(600, 4'b0000, 1'b1, 1, MAX_HOLD + 3, 2);
    run(4, 4'b0000, 1'b0, 1, 1, 0);
    @(negedge clock);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
